// File: rtl/mmu_arbiter.sv
// mmu_arbiter: shares the single MMU port between two requesters.
//   m0 = CPU load/store/fetch, m1 = debug/UART memory dumper.
//   One MMU transaction at a time: IDLE -> BUSY -> DONE -> IDLE.
//   Arbitration is round-robin (RR_ENABLE=1) or fixed priority with m0 winning
//   (RR_ENABLE=0). A BUSY phase lasting TIMEOUT_CYCLES cycles without
//   mmu_mem_ready aborts the access with mN_error (0 disables the timeout).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   mN_read_enable/write_enable   requests (write wins if both are high)
//   mN_signed_read, mN_data_width access attributes, forwarded unchanged
//   mN_address, mN_data_in        byte address and write data
//   mN_data_out                   read data of the last completion on port N
//   mN_mem_ready, mN_error        one-cycle completion pulse / timeout flag
//   mmu_*                         registered request fields to the MMU
//   mmu_data_out, mmu_mem_ready   response from the MMU
//   arb_busy                      high in BUSY and DONE
//   arb_grant                     owner of the current or last transaction
module mmu_arbiter #(
    parameter int RR_ENABLE      = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_WIDTH       = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_read_enable,
    input  logic        m0_write_enable,
    input  logic        m0_signed_read,
    input  logic [1:0]  m0_data_width,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_in,
    output logic [31:0] m0_data_out,
    output logic        m0_mem_ready,
    output logic        m0_error,
    input  logic        m1_read_enable,
    input  logic        m1_write_enable,
    input  logic        m1_signed_read,
    input  logic [1:0]  m1_data_width,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_in,
    output logic [31:0] m1_data_out,
    output logic        m1_mem_ready,
    output logic        m1_error,
    output logic        mmu_read_enable,
    output logic        mmu_write_enable,
    output logic        mmu_signed_read,
    output logic [1:0]  mmu_data_width,
    output logic [31:0] mmu_address,
    output logic [31:0] mmu_data_in,
    input  logic [31:0] mmu_data_out,
    input  logic        mmu_mem_ready,
    output logic        arb_busy,
    output logic        arb_grant
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

    logic [1:0]          r_state;
    logic                r_last_grant;
    logic [TO_WIDTH-1:0] r_to_cnt;
    logic                r_grant;
    logic                r_busy;
    logic                r_mmu_re;
    logic                r_mmu_we;
    logic                r_mmu_sr;
    logic [1:0]          r_mmu_dw;
    logic [31:0]         r_mmu_addr;
    logic [31:0]         r_mmu_din;
    logic [31:0]         r_dout [2];
    logic [1:0]          r_ready;
    logic [1:0]          r_error;

    // Per-port request views, indexed by port number.
    logic [1:0]  w_rd;
    logic [1:0]  w_wr;
    logic [1:0]  w_pend;
    logic [1:0]  w_rd_only;
    logic        w_win;
    logic        w_timeout;
    logic [TO_WIDTH-1:0] w_to_next;

    assign w_rd = {m1_read_enable, m0_read_enable};
    assign w_wr = {m1_write_enable, m0_write_enable};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign w_pend[gi]    = w_rd[gi] | w_wr[gi];
            // A simultaneous write suppresses the read.
            assign w_rd_only[gi] = w_rd[gi] & ~w_wr[gi];
        end
    endgenerate

    // Winner is only meaningful when at least one request is pending.
    always_comb begin
        w_win = 1'b0;
        if (RR_ENABLE != 0) begin
            if (w_pend[0] && w_pend[1])
                w_win = ~r_last_grant;
            else
                w_win = w_pend[1];
        end else begin
            w_win = ~w_pend[0];
        end
    end

    assign w_to_next = r_to_cnt + 1'b1;
    // w_to_next counts the BUSY cycle ending at this edge, so the abort fires
    // on the TIMEOUT_CYCLES-th BUSY edge.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_to_next == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_to_cnt     <= '0;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_mmu_re     <= 1'b0;
            r_mmu_we     <= 1'b0;
            r_mmu_sr     <= 1'b0;
            r_mmu_dw     <= 2'd0;
            r_mmu_addr   <= 32'd0;
            r_mmu_din    <= 32'd0;
            r_dout[0]    <= 32'd0;
            r_dout[1]    <= 32'd0;
            r_ready      <= 2'b00;
            r_error      <= 2'b00;
        end else begin
            // Completion flags are single-cycle pulses.
            r_ready <= 2'b00;
            r_error <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (|w_pend) begin
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                        r_busy       <= 1'b1;
                        r_to_cnt     <= '0;
                        r_mmu_re     <= w_rd_only[w_win];
                        r_mmu_we     <= w_wr[w_win];
                        r_mmu_sr     <= w_win ? m1_signed_read : m0_signed_read;
                        r_mmu_dw     <= w_win ? m1_data_width  : m0_data_width;
                        r_mmu_addr   <= w_win ? m1_address     : m0_address;
                        r_mmu_din    <= w_win ? m1_data_in     : m0_data_in;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_to_cnt <= w_to_next;
                    if (mmu_mem_ready) begin
                        r_mmu_re         <= 1'b0;
                        r_mmu_we         <= 1'b0;
                        r_dout[r_grant]  <= mmu_data_out;
                        r_ready[r_grant] <= 1'b1;
                        r_state          <= S_DONE;
                    end else if (w_timeout) begin
                        r_mmu_re         <= 1'b0;
                        r_mmu_we         <= 1'b0;
                        r_dout[r_grant]  <= 32'd0;
                        r_ready[r_grant] <= 1'b1;
                        r_error[r_grant] <= 1'b1;
                        r_state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_data_out      = r_dout[0];
    assign m1_data_out      = r_dout[1];
    assign m0_mem_ready     = r_ready[0];
    assign m1_mem_ready     = r_ready[1];
    assign m0_error         = r_error[0];
    assign m1_error         = r_error[1];
    assign mmu_read_enable  = r_mmu_re;
    assign mmu_write_enable = r_mmu_we;
    assign mmu_signed_read  = r_mmu_sr;
    assign mmu_data_width   = r_mmu_dw;
    assign mmu_address      = r_mmu_addr;
    assign mmu_data_in      = r_mmu_din;
    assign arb_busy         = r_busy;
    assign arb_grant        = r_grant;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Testbench for mmu_arbiter. Two instances share all inputs:
//   u0 = round-robin, u1 = fixed priority; both with an 8-cycle timeout.
module tb_mmu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_re, m0_we, m0_sr, m1_re, m1_we, m1_sr;
    logic [1:0]  m0_dw, m1_dw;
    logic [31:0] m0_addr, m0_din, m1_addr, m1_din;
    logic [31:0] mmu_dout;
    logic        mmu_rdy;

    logic [31:0] o_m0_dout [2];
    logic [31:0] o_m1_dout [2];
    logic        o_m0_rdy [2];
    logic        o_m1_rdy [2];
    logic        o_m0_err [2];
    logic        o_m1_err [2];
    logic        o_re [2];
    logic        o_we [2];
    logic        o_sr [2];
    logic [1:0]  o_dw [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_din [2];
    logic        o_busy [2];
    logic        o_grant [2];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mmu_arbiter #(
                .RR_ENABLE     ((gi == 0) ? 1 : 0),
                .TIMEOUT_CYCLES(8),
                .TO_WIDTH      (4)
            ) u_dut (
                .clk             (clk),
                .reset           (reset),
                .m0_read_enable  (m0_re),
                .m0_write_enable (m0_we),
                .m0_signed_read  (m0_sr),
                .m0_data_width   (m0_dw),
                .m0_address      (m0_addr),
                .m0_data_in      (m0_din),
                .m0_data_out     (o_m0_dout[gi]),
                .m0_mem_ready    (o_m0_rdy[gi]),
                .m0_error        (o_m0_err[gi]),
                .m1_read_enable  (m1_re),
                .m1_write_enable (m1_we),
                .m1_signed_read  (m1_sr),
                .m1_data_width   (m1_dw),
                .m1_address      (m1_addr),
                .m1_data_in      (m1_din),
                .m1_data_out     (o_m1_dout[gi]),
                .m1_mem_ready    (o_m1_rdy[gi]),
                .m1_error        (o_m1_err[gi]),
                .mmu_read_enable (o_re[gi]),
                .mmu_write_enable(o_we[gi]),
                .mmu_signed_read (o_sr[gi]),
                .mmu_data_width  (o_dw[gi]),
                .mmu_address     (o_addr[gi]),
                .mmu_data_in     (o_din[gi]),
                .mmu_data_out    (mmu_dout),
                .mmu_mem_ready   (mmu_rdy),
                .arb_busy        (o_busy[gi]),
                .arb_grant       (o_grant[gi])
            );
        end
    endgenerate

    typedef struct {
        logic        r0, w0, s0, r1, w1, s1;
        logic [1:0]  dw0, dw1;
        logic [31:0] a0, d0, a1, d1;
        int          k;        // MMU answers on the k-th BUSY edge
        logic [31:0] rdata;
        logic        g_rr;     // expected grant, round-robin instance
        logic        g_fp;     // expected grant, fixed-priority instance
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_dout [2][2];   // [instance][port]

    task automatic chk(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s u%0d: got 0x%08h expected 0x%08h", name, inst, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_re = 0; m0_we = 0; m0_sr = 0; m0_dw = 0; m0_addr = 0; m0_din = 0;
        m1_re = 0; m1_we = 0; m1_sr = 0; m1_dw = 0; m1_addr = 0; m1_din = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_dout[i][0] = 32'd0;
            exp_dout[i][1] = 32'd0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic g;
        logic exp_we, exp_re;
        @(negedge clk);
        m0_re = v.r0; m0_we = v.w0; m0_sr = v.s0; m0_dw = v.dw0; m0_addr = v.a0; m0_din = v.d0;
        m1_re = v.r1; m1_we = v.w1; m1_sr = v.s1; m1_dw = v.dw1; m1_addr = v.a1; m1_din = v.d1;
        mmu_rdy = 1'b0;
        mmu_dout = v.rdata;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            g      = (i == 0) ? v.g_rr : v.g_fp;
            exp_we = g ? v.w1 : v.w0;
            exp_re = g ? (v.r1 & ~v.w1) : (v.r0 & ~v.w0);
            chk($sformatf("v%0d grant", idx), i, 32'(o_grant[i]), 32'(g));
            chk($sformatf("v%0d busy", idx), i, 32'(o_busy[i]), 32'd1);
            chk($sformatf("v%0d mmu_we", idx), i, 32'(o_we[i]), 32'(exp_we));
            chk($sformatf("v%0d mmu_re", idx), i, 32'(o_re[i]), 32'(exp_re));
            chk($sformatf("v%0d mmu_addr", idx), i, o_addr[i], g ? v.a1 : v.a0);
            chk($sformatf("v%0d mmu_din", idx), i, o_din[i], g ? v.d1 : v.d0);
            chk($sformatf("v%0d mmu_sr", idx), i, 32'(o_sr[i]), 32'(g ? v.s1 : v.s0));
            chk($sformatf("v%0d mmu_dw", idx), i, 32'(o_dw[i]), 32'(g ? v.dw1 : v.dw0));
        end
        for (int c = 1; c <= v.k; c++) begin
            @(negedge clk);
            mmu_rdy = (c == v.k);
            @(posedge clk); #1;
            if (c < v.k) begin
                for (int i = 0; i < 2; i++) begin
                    g = (i == 0) ? v.g_rr : v.g_fp;
                    chk($sformatf("v%0d hold_en", idx), i, 32'(o_re[i] | o_we[i]), 32'd1);
                    chk($sformatf("v%0d early_rdy", idx), i, 32'(o_m0_rdy[i] | o_m1_rdy[i]), 32'd0);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            g = (i == 0) ? v.g_rr : v.g_fp;
            exp_dout[i][g] = v.rdata;
            chk($sformatf("v%0d m0_rdy", idx), i, 32'(o_m0_rdy[i]), 32'(g == 1'b0));
            chk($sformatf("v%0d m1_rdy", idx), i, 32'(o_m1_rdy[i]), 32'(g == 1'b1));
            chk($sformatf("v%0d err", idx), i, 32'(o_m0_err[i] | o_m1_err[i]), 32'd0);
            chk($sformatf("v%0d done_en", idx), i, 32'(o_re[i] | o_we[i]), 32'd0);
            chk($sformatf("v%0d m0_dout", idx), i, o_m0_dout[i], exp_dout[i][0]);
            chk($sformatf("v%0d m1_dout", idx), i, o_m1_dout[i], exp_dout[i][1]);
        end
        @(negedge clk);
        idle_inputs();
        mmu_rdy = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("v%0d idle_busy", idx), i, 32'(o_busy[i]), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   npulse [2];
        int   last_cyc [2];
        logic port;

        //            r0 w0 s0 r1 w1 s1 dw0 dw1 a0          d0          a1          d1          k  rdata         rr  fp
        vecs[0] = '{1, 0, 0, 0, 0, 0, 2, 0, 32'h100, 32'h0,        32'h0,   32'h0,        2, 32'hDEADBEEF, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 1, 0, 0, 1, 32'h0,   32'h0,        32'h200, 32'h12345678, 1, 32'h00000011, 1, 1};
        vecs[2] = '{0, 1, 0, 0, 1, 0, 2, 2, 32'h300, 32'hA0,       32'h304, 32'hA1,       1, 32'h00000022, 0, 0};
        vecs[3] = '{0, 1, 0, 0, 1, 0, 2, 2, 32'h300, 32'hA0,       32'h304, 32'hA1,       1, 32'h00000033, 1, 0};
        vecs[4] = '{0, 1, 0, 0, 1, 0, 2, 2, 32'h300, 32'hA0,       32'h304, 32'hA1,       1, 32'h00000044, 0, 0};
        vecs[5] = '{0, 1, 0, 0, 1, 0, 2, 2, 32'h300, 32'hA0,       32'h304, 32'hA1,       2, 32'h00000055, 1, 0};
        vecs[6] = '{1, 1, 0, 0, 0, 0, 2, 0, 32'h40,  32'h77,       32'h0,   32'h0,        1, 32'h00000066, 0, 0};
        vecs[7] = '{0, 0, 0, 1, 0, 1, 0, 0, 32'h0,   32'h0,        32'h800, 32'h0,        3, 32'hFFFFFF80, 1, 1};
        vecs[8] = '{1, 0, 0, 1, 0, 0, 1, 1, 32'h900, 32'h0,        32'h904, 32'h0,        1, 32'h00000099, 0, 0};

        idle_inputs();
        mmu_rdy  = 1'b0;
        mmu_dout = 32'h0;
        reset    = 1'b1;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset busy",  i, 32'(o_busy[i]), 32'd0);
            chk("reset grant", i, 32'(o_grant[i]), 32'd0);
            chk("reset en",    i, 32'(o_re[i] | o_we[i] | o_sr[i]), 32'd0);
            chk("reset addr",  i, o_addr[i], 32'd0);
            chk("reset rdy",   i, 32'(o_m0_rdy[i] | o_m1_rdy[i] | o_m0_err[i] | o_m1_err[i]), 32'd0);
            chk("reset dout",  i, o_m0_dout[i] | o_m1_dout[i], 32'd0);
        end

        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v], v);
            $display("vector %0d applied: grant rr=%0d fp=%0d checks=%0d",
                     v, vecs[v].g_rr, vecs[v].g_fp, n_checks);
        end

        // Timeout: m1 read with the MMU never answering.
        @(negedge clk);
        m1_re = 1'b1; m1_addr = 32'h500;
        mmu_rdy = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk("to grant", i, 32'(o_grant[i]), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (c < 8) begin
                    chk("to early_rdy", i, 32'(o_m1_rdy[i]), 32'd0);
                end else begin
                    exp_dout[i][1] = 32'd0;
                    chk("to m1_rdy", i, 32'(o_m1_rdy[i]), 32'd1);
                    chk("to m1_err", i, 32'(o_m1_err[i]), 32'd1);
                    chk("to m1_dout", i, o_m1_dout[i], 32'd0);
                    chk("to m0_rdy", i, 32'(o_m0_rdy[i]), 32'd0);
                    chk("to m0_dout", i, o_m0_dout[i], exp_dout[i][0]);
                end
            end
        end
        $display("timeout transaction: m1_error=%0d m1_data_out=0x%08h", o_m1_err[0], o_m1_dout[0]);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        vecs[0] = '{0, 0, 0, 1, 0, 0, 0, 2, 32'h0, 32'h0, 32'h504, 32'h0, 1, 32'h13579BDF, 1, 1};
        run_vec(vecs[0], 9);
        $display("post-timeout transaction: m1_data_out=0x%08h", o_m1_dout[0]);

        // Both requesters write continuously, MMU answers in one cycle.
        do_reset();
        m0_we = 1'b1; m0_addr = 32'hA00;
        m1_we = 1'b1; m1_addr = 32'hB00;
        mmu_rdy  = 1'b1;
        mmu_dout = 32'hCAFE0000;
        npulse   = '{0, 0};
        last_cyc = '{0, 0};
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (o_m0_rdy[i] || o_m1_rdy[i]) begin
                    port = o_m1_rdy[i];
                    chk("cont port", i, 32'(port), (i == 0) ? 32'(npulse[i] % 2) : 32'd0);
                    chk("cont dout", i, port ? o_m1_dout[i] : o_m0_dout[i], 32'hCAFE0000);
                    if (npulse[i] > 0)
                        chk("cont spacing", i, 32'(c - last_cyc[i]), 32'd3);
                    $display("u%0d completion at cycle %0d on m%0d", i, c, port);
                    last_cyc[i] = c;
                    npulse[i]++;
                end
            end
        end
        for (int i = 0; i < 2; i++)
            chk("cont count", i, 32'(npulse[i]), 32'd6);
        // m0 withdraws: m1 must now be served by both arbiters.
        @(negedge clk);
        m0_we = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("drop grant", i, 32'(o_grant[i]), 32'd1);
            chk("drop addr",  i, o_addr[i], 32'hB00);
        end
        @(negedge clk);
        idle_inputs();
        repeat (4) @(posedge clk);

        // Reset on the second BUSY cycle of an m0 write.
        @(negedge clk);
        m0_we = 1'b1; m0_addr = 32'h600;
        mmu_rdy = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk("rst busy1", i, 32'(o_busy[i] & o_we[i]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst en",   i, 32'(o_re[i] | o_we[i]), 32'd0);
            chk("rst busy", i, 32'(o_busy[i]), 32'd0);
            chk("rst rdy",  i, 32'(o_m0_rdy[i]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        m1_we = 1'b1; m1_addr = 32'h700;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst tie grant", i, 32'(o_grant[i]), 32'd0);
            chk("rst tie rdy",   i, 32'(o_m0_rdy[i] | o_m1_rdy[i]), 32'd0);
        end
        @(negedge clk);
        mmu_rdy = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk("rst tie done", i, 32'(o_m0_rdy[i]), 32'd1);
        $display("reset sequence: tie after reset granted m%0d", o_grant[0]);
        @(negedge clk);
        idle_inputs();
        mmu_rdy = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
